// File: rtl/project_mux_ctrl_if.sv
// Wishbone slave port bundle between the SoC bus and the project mux controller.
`timescale 1ns/1ps
interface project_mux_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/project_mux_ctrl.sv
// Shares the user IO pads between NPROJ projects; every switchover goes
// reset -> pads hi-Z -> mux change -> reset release.
//
//   state   | meaning
//   IDLE    | active project out of reset, pads driven by it
//   HOLD    | all projects in reset, pads hi-Z, GUARD cycles
//   SWITCH  | one cycle, mux select moves to the requested project
//   RELEASE | pads hi-Z, new project held in reset for RST_HOLD cycles
`timescale 1ns/1ps
module project_mux_ctrl #(
    parameter int          NPROJ     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          GUARD     = 8,
    parameter int          RST_HOLD  = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    project_mux_ctrl_if.slave    wb,
    output logic [3:0]           proj_sel_o,
    output logic [NPROJ-1:0]     proj_rst_n_o,
    output logic [1:0]           custom_settings_o,
    output logic                 io_force_hiz_o,
    output logic                 busy_o
);
    localparam int CMAX = (GUARD > RST_HOLD) ? GUARD : RST_HOLD;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, HOLD, SWITCH, RELEASE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [3:0]      pend_sel;
    logic            sel_err;
    logic            enter_hold, load_sel, release_rst;
    logic            hit, req, wr_en, ctrl_wr, set_wr, sel_ok;
    logic [31:0]     rd_val;
    logic [NPROJ-1:0] rst_vec;
    logic            unused_ok;

    assign unused_ok = ^{wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:4], wb.wbs_adr_i[1:0]};

    assign hit     = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req     = wb.wbs_cyc_i & wb.wbs_stb_i & hit;
    // Writes commit at the end of the ack cycle, gated by the low byte lane.
    assign wr_en   = wb.wbs_ack_o & req & wb.wbs_we_i & wb.wbs_sel_i[0];
    assign ctrl_wr = wr_en & (wb.wbs_adr_i[3:2] == 2'd0);
    assign set_wr  = wr_en & (wb.wbs_adr_i[3:2] == 2'd1);
    assign sel_ok  = (32'(wb.wbs_dat_i[3:0]) < 32'(NPROJ));
    assign busy_o  = (state != IDLE);

    always_comb begin
        rd_val = '0;
        case (wb.wbs_adr_i[3:2])
            2'd0:    rd_val[3:0] = proj_sel_o;
            2'd1:    rd_val[1:0] = custom_settings_o;
            2'd2:    rd_val[7:0] = {proj_sel_o, 2'b00, sel_err, busy_o};
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        rst_vec = '0;
        for (int i = 0; i < NPROJ; i++) rst_vec[i] = (proj_sel_o == 4'(i));
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        enter_hold  = 1'b0;
        load_sel    = 1'b0;
        release_rst = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_wr && sel_ok) begin
                    state_nxt  = HOLD;
                    cnt_nxt    = '0;
                    enter_hold = 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CW'(GUARD - 1)) begin
                    state_nxt = SWITCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SWITCH: begin
                load_sel  = 1'b1;
                state_nxt = RELEASE;
                cnt_nxt   = '0;
            end
            RELEASE: begin
                if (cnt == CW'(RST_HOLD - 1)) begin
                    state_nxt   = IDLE;
                    release_rst = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            proj_sel_o        <= '0;
            proj_rst_n_o      <= '0;
            custom_settings_o <= '0;
            io_force_hiz_o    <= 1'b1;
            pend_sel          <= '0;
            sel_err           <= 1'b0;
            wb.wbs_ack_o      <= 1'b0;
            wb.wbs_dat_o      <= '0;
        end else begin
            wb.wbs_ack_o <= req & ~wb.wbs_ack_o;
            wb.wbs_dat_o <= (req & ~wb.wbs_ack_o) ? rd_val : '0;
            if (enter_hold) begin
                proj_rst_n_o   <= '0;
                io_force_hiz_o <= 1'b1;
                pend_sel       <= wb.wbs_dat_i[3:0];
            end
            if (load_sel) proj_sel_o <= pend_sel;
            // Reset release and pad enable move on the same edge.
            if (release_rst) begin
                proj_rst_n_o   <= rst_vec;
                io_force_hiz_o <= 1'b0;
            end
            if (set_wr) custom_settings_o <= wb.wbs_dat_i[1:0];
            if (ctrl_wr && state == IDLE) sel_err <= ~sel_ok;
        end
    end
endmodule

// File: tb/tb_project_mux_ctrl.sv
// Directed bench for project_mux_ctrl: switch sequencing, register access and reset abort.
`timescale 1ns/1ps
module tb_project_mux_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic       wb_clk_i = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] proj_sel_o;
    logic [3:0] proj_rst_n_o;
    logic [1:0] custom_settings_o;
    logic       io_force_hiz_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int inv_viol = 0;

    project_mux_ctrl_if wb();

    project_mux_ctrl #(.NPROJ(4), .BASE_ADDR(BASE), .GUARD(8), .RST_HOLD(16)) dut (
        .wb_clk_i          (wb_clk_i),
        .rst_n             (rst_n),
        .wb                (wb),
        .proj_sel_o        (proj_sel_o),
        .proj_rst_n_o      (proj_rst_n_o),
        .custom_settings_o (custom_settings_o),
        .io_force_hiz_o    (io_force_hiz_o),
        .busy_o            (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Safety invariant: at most one project out of reset, never while hi-Z.
    always @(negedge wb_clk_i) begin
        if (io_force_hiz_o && (|proj_rst_n_o)) inv_viol++;
        if ($countones(proj_rst_n_o) > 1) inv_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    // Entered and left at posedge+1; returns one cycle after the ack cycle.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output logic acked);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        acked = 1'b0;
        rd    = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(negedge wb_clk_i);
            if (wb.wbs_ack_o) begin
                acked = 1'b1;
                rd    = wb.wbs_dat_o;
            end
            @(posedge wb_clk_i);
            #1;
        end
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] dat,
                      input logic [3:0] sel);
        logic [31:0] rd;
        logic        ak;
        wb_xfer(1'b1, BASE + off, dat, sel, rd, ak);
        chk({tag, "_ack"}, 32'(ak), 1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ak;
        wb_xfer(1'b0, BASE + off, 32'h0, 4'hf, rd, ak);
        chk({tag, "_ack"}, 32'(ak), 1);
        chk(tag, rd, exp);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && busy_o; i++) step(1);
        chk("wait_idle", 32'(busy_o), 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ak;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;

        // Reset state
        step(3);
        chk("rst_sel",  32'(proj_sel_o), 0);
        chk("rst_rstn", 32'(proj_rst_n_o), 0);
        chk("rst_set",  32'(custom_settings_o), 0);
        chk("rst_hiz",  32'(io_force_hiz_o), 1);
        chk("rst_ack",  32'(wb.wbs_ack_o), 0);
        chk("rst_dat",  wb.wbs_dat_o, 0);

        // 1: project 0 released 16 cycles after reset deassertion
        rst_n = 1'b1;
        step(15);
        chk("t1_rstn_early", 32'(proj_rst_n_o), 0);
        chk("t1_hiz_early",  32'(io_force_hiz_o), 1);
        step(1);
        chk("t1_rstn", 32'(proj_rst_n_o), 4'b0001);
        chk("t1_hiz",  32'(io_force_hiz_o), 0);
        chk("t1_busy", 32'(busy_o), 0);

        // 3: out-of-range select sets sel_err and changes nothing
        wr("t3_wr7", 32'h0, 32'd7, 4'h1);
        chk("t3_ack_single", 32'(wb.wbs_ack_o), 0);
        chk("t3_busy", 32'(busy_o), 0);
        chk("t3_rstn", 32'(proj_rst_n_o), 4'b0001);
        rd_chk("t3_status", 32'h8, 32'h02);
        rd_chk("t3_ctrl",   32'h0, 32'h0);
        wr("t3_wr1", 32'h0, 32'd1, 4'h1);
        chk("t3_busy1", 32'(busy_o), 1);
        rd_chk("t3_status_clr", 32'h8, 32'h01);
        wait_idle(60);
        chk("t3_sel1",  32'(proj_sel_o), 1);
        chk("t3_rstn1", 32'(proj_rst_n_o), 4'b0010);

        // 2: exact switch timing to project 2
        wr("t2_wr2", 32'h0, 32'd2, 4'h1);
        chk("t2_rstn_e0", 32'(proj_rst_n_o), 0);
        chk("t2_hiz_e0",  32'(io_force_hiz_o), 1);
        chk("t2_busy_e0", 32'(busy_o), 1);
        step(8);
        chk("t2_sel_switch", 32'(proj_sel_o), 1);
        step(1);
        chk("t2_sel_new", 32'(proj_sel_o), 2);
        chk("t2_hiz_sw",  32'(io_force_hiz_o), 1);
        step(15);
        chk("t2_rstn_late", 32'(proj_rst_n_o), 0);
        chk("t2_hiz_late",  32'(io_force_hiz_o), 1);
        step(1);
        chk("t2_rstn", 32'(proj_rst_n_o), 4'b0100);
        chk("t2_hiz",  32'(io_force_hiz_o), 0);
        chk("t2_busy", 32'(busy_o), 0);

        // 4: write while busy and write with no byte lane are both ignored
        wr("t4_wr1", 32'h0, 32'd1, 4'h1);
        wr("t4_wr3_busy", 32'h0, 32'd3, 4'h1);
        wait_idle(60);
        chk("t4_sel", 32'(proj_sel_o), 1);
        chk("t4_rstn", 32'(proj_rst_n_o), 4'b0010);
        rd_chk("t4_status", 32'h8, 32'h10);
        wr("t4_wr_nosel", 32'h0, 32'd3, 4'h0);
        chk("t4_nosel_busy", 32'(busy_o), 0);
        rd_chk("t4_ctrl", 32'h0, 32'h1);
        rd_chk("t4_hole", 32'hC, 32'h0);
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hf, rd, ak);
        chk("t4_outside_noack", 32'(ak), 0);

        // 5: settings write during RELEASE, timing unchanged
        wr("t5_wr2", 32'h0, 32'd2, 4'h1);
        step(10);
        wr("t5_set", 32'h4, 32'h2, 4'h1);
        chk("t5_settings", 32'(custom_settings_o), 2'b10);
        step(12);
        chk("t5_rstn_late", 32'(proj_rst_n_o), 0);
        step(1);
        chk("t5_rstn", 32'(proj_rst_n_o), 4'b0100);
        chk("t5_hiz",  32'(io_force_hiz_o), 0);
        rd_chk("t5_set_rd", 32'h4, 32'h2);

        // 6: reset mid-HOLD aborts and replays the project 0 release
        wr("t6_wr3", 32'h0, 32'd3, 4'h1);
        step(3);
        rst_n = 1'b0;
        #1;
        chk("t6_sel",  32'(proj_sel_o), 0);
        chk("t6_rstn", 32'(proj_rst_n_o), 0);
        chk("t6_set",  32'(custom_settings_o), 0);
        chk("t6_hiz",  32'(io_force_hiz_o), 1);
        step(2);
        rst_n = 1'b1;
        step(15);
        chk("t6_rstn_early", 32'(proj_rst_n_o), 0);
        step(1);
        chk("t6_rstn_rel", 32'(proj_rst_n_o), 4'b0001);
        chk("t6_hiz_rel",  32'(io_force_hiz_o), 0);
        step(30);
        chk("t6_no_pending", 32'(busy_o), 0);
        chk("t6_sel_kept",   32'(proj_sel_o), 0);
        rd_chk("t6_status", 32'h8, 32'h00);

        chk("invariant", 32'(inv_viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
